// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory and buffers {instr, pc} for the IR.
// Define PREFETCH_EN for a two-entry buffer (one instruction per cycle); otherwise the buffer holds one word.
module fetch_unit #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_pc_load,
    input  logic [ADDR_W-1:0] i_pc_load_value,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    input  logic              i_mem_ready,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic [DATA_W-1:0] o_ir_data,
    output logic [ADDR_W-1:0] o_ir_pc,
    output logic              o_ir_valid,
    input  logic              i_ir_ready,
    output logic              o_fetch_busy
);

`ifdef PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef enum logic [1:0] {S_EMPTY, S_PART, S_FULL} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_buf_data [2];
    logic [ADDR_W-1:0] r_buf_pc   [2];
    logic              w_push;
    logic              w_pop;
    logic              w_head_free;

    // Read request depends only on registered occupancy, gated off while reset is held.
    assign o_mem_rd     = !i_reset && (r_state != S_FULL);
    assign o_mem_addr   = r_pc;
    assign o_fetch_busy = o_mem_rd && !i_mem_ready;
    assign o_ir_valid   = (r_state != S_EMPTY);
    assign o_ir_data    = r_buf_data[0];
    assign o_ir_pc      = r_buf_pc[0];

    assign w_push      = o_mem_rd && i_mem_ready && !i_pc_load;
    assign w_pop       = o_ir_valid && i_ir_ready;
    assign w_head_free = (r_state == S_EMPTY) || w_pop;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_pc_load) begin
            w_next = S_EMPTY;
        end else if (w_push && !w_pop) begin
            case (r_state)
                S_EMPTY: w_next = (DEPTH == 2) ? S_PART : S_FULL;
                S_PART:  w_next = S_FULL;
                default: w_next = r_state;
            endcase
        end else if (w_pop && !w_push) begin
            case (r_state)
                S_FULL:  w_next = (DEPTH == 2) ? S_PART : S_EMPTY;
                S_PART:  w_next = S_EMPTY;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pc <= RESET_PC;
            for (int i = 0; i < 2; i++) begin
                r_buf_data[i] <= '0;
                r_buf_pc[i]   <= '0;
            end
        end else if (i_pc_load) begin
            // Redirect wins: any same-cycle transfer is dropped and the PC is not advanced.
            r_pc <= i_pc_load_value;
        end else begin
            if (w_pop && r_state == S_FULL && DEPTH == 2) begin
                r_buf_data[0] <= r_buf_data[1];
                r_buf_pc[0]   <= r_buf_pc[1];
            end
            if (w_push) begin
                r_pc <= r_pc + ADDR_W'(1);
                if (w_head_free) begin
                    r_buf_data[0] <= i_mem_data;
                    r_buf_pc[0]   <= r_pc;
                end else begin
                    r_buf_data[1] <= i_mem_data;
                    r_buf_pc[1]   <= r_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference PC/buffer model predicts every output each cycle.
module tb_fetch_unit;

`ifdef PREFETCH_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_value = 16'h0000;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_data;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        fetch_busy;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] q[$];
    logic [15:0] exp_pc = 16'h0000;
    logic        exp_rd;

    fetch_unit #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .i_clock(clock), .i_reset(reset),
        .i_pc_load(pc_load), .i_pc_load_value(pc_load_value),
        .o_mem_addr(mem_addr), .o_mem_rd(mem_rd),
        .i_mem_ready(mem_ready), .i_mem_data(mem_data),
        .o_ir_data(ir_data), .o_ir_pc(ir_pc), .o_ir_valid(ir_valid),
        .i_ir_ready(ir_ready), .o_fetch_busy(fetch_busy)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] memf(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1111;
            16'h0001: return 16'h2222;
            16'h0002: return 16'h3333;
            default:  return a ^ 16'h5A3C;
        endcase
    endfunction

    assign mem_data = memf(mem_addr);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Inputs change at the falling edge; the model samples 2 time units later and
    // predicts what the following rising edge will do.
    always begin
        @(negedge clock);
        #2;
        if (reset) begin
            chk("rst_mem_rd", mem_rd, 1'b0);
            chk("rst_ir_valid", ir_valid, 1'b0);
            chk("rst_ir_data", ir_data, 16'h0000);
            chk("rst_ir_pc", ir_pc, 16'h0000);
            chk("rst_mem_addr", mem_addr, 16'h0000);
            chk("rst_busy", fetch_busy, 1'b0);
            q.delete();
            exp_pc = 16'h0000;
        end else begin
            exp_rd = (q.size() < D);
            chk("mem_rd", mem_rd, exp_rd);
            chk("mem_addr", mem_addr, exp_pc);
            chk("ir_valid", ir_valid, q.size() != 0);
            chk("fetch_busy", fetch_busy, exp_rd && !mem_ready);
            if (q.size() != 0) begin
                chk("ir_data", ir_data, q[0][31:16]);
                chk("ir_pc", ir_pc, q[0][15:0]);
                if (ir_ready) void'(q.pop_front());
            end
            if (pc_load) begin
                q.delete();
                exp_pc = pc_load_value;
            end else if (exp_rd && mem_ready) begin
                q.push_back({memf(exp_pc), exp_pc});
                exp_pc = exp_pc + 16'h0001;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        // reset held, then released
        cycles(2);
        reset = 1'b0;
        cycles(1);
        // zero-wait stream
        mem_ready = 1'b1;
        ir_ready  = 1'b1;
        cycles(8);
        // backpressure, then drain
        ir_ready = 1'b0;
        cycles(5);
        ir_ready = 1'b1;
        cycles(6);
        // redirect with a full buffer and memory ready
        ir_ready = 1'b0;
        cycles(4);
        pc_load = 1'b1;
        pc_load_value = 16'h0040;
        cycles(1);
        pc_load = 1'b0;
        ir_ready = 1'b1;
        cycles(4);
        // back-to-back redirects while streaming; the second discards an in-flight transfer
        pc_load = 1'b1;
        pc_load_value = 16'h0100;
        cycles(1);
        pc_load_value = 16'h0200;
        cycles(1);
        pc_load = 1'b0;
        cycles(4);
        // PC wrap
        pc_load = 1'b1;
        pc_load_value = 16'hFFFF;
        cycles(1);
        pc_load = 1'b0;
        cycles(6);
        // wait states, then reset in the second wait cycle
        pc_load = 1'b1;
        pc_load_value = 16'h0010;
        cycles(1);
        pc_load = 1'b0;
        mem_ready = 1'b0;
        cycles(1);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        mem_ready = 1'b1;
        cycles(6);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
